// File: rtl/prio_enc_pkg.sv
// Shared constants for the priority encoder/arbiter and its 7-segment display.
// Glyphs are active-low, with segment a..g on bit6..bit0.
package prio_enc_pkg;

    localparam int unsigned MODE_FIXED = 0;
    localparam int unsigned MODE_RR    = 1;

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // Entry 0 sits in the rightmost slot, so the list below runs F down to 0.
    localparam logic [15:0][6:0] SEG7_TABLE = {
        7'h38, 7'h30, 7'h42, 7'h31, 7'h60, 7'h08, 7'h04, 7'h00,
        7'h0F, 7'h20, 7'h24, 7'h4C, 7'h06, 7'h12, 7'h4F, 7'h01
    };

endpackage

// File: rtl/prio_encoder_rr_seg7.sv
// One hex digit of active-low 7-segment output.
// The digit goes dark when blank is asserted.
module hex_to_seg7
    import prio_enc_pkg::*;
(
    input  logic [3:0] hex,
    input  logic       blank,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_BLANK;
        if (!blank) seg = SEG7_TABLE[hex];
    end

endmodule

// File: rtl/prio_encoder_rr.sv
// Registered N-input priority encoder/arbiter with a valid/ack handshake.
// Supports fixed (MSB-first) or round-robin priority and drives a hex display of the grant.
module prio_encoder_rr
    import prio_enc_pkg::*;
#(
    parameter int unsigned N      = 16,
    parameter int unsigned IDX_W  = $clog2(N),
    parameter int unsigned MODE   = MODE_FIXED,
    parameter int unsigned DIGITS = (IDX_W + 3) / 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [N-1:0]          data,
    input  logic                  en,
    input  logic                  out_ack,
    output logic [IDX_W-1:0]      out,
    output logic                  inputValid,
    output logic                  multi,
    output logic [7*DIGITS-1:0]   seg
);

    localparam logic [IDX_W-1:0] PTR_MAX = IDX_W'(N - 1);

    // Rotate so bit p lands on the MSB, pick the highest set bit, then map it back.
    function automatic logic [IDX_W-1:0] pick(input logic [N-1:0] req,
                                              input logic [IDX_W-1:0] p);
        logic [2*N-1:0] dbl;
        logic [N-1:0]   rot;
        int unsigned    hi;
        int unsigned    idx;
        logic           found;
        dbl   = {req, req} >> (32'(p) + 32'd1);
        rot   = dbl[N-1:0];
        hi    = 0;
        found = 1'b0;
        for (int unsigned j = 0; j < N; j++) begin
            if (rot[j]) begin
                hi    = j;
                found = 1'b1;
            end
        end
        idx = hi + 32'(p) + 32'd1;
        if (idx >= N) idx = idx - N;
        return found ? IDX_W'(idx) : '0;
    endfunction

    logic [IDX_W-1:0]    ptr;
    logic [IDX_W-1:0]    ptr_eff;
    logic                load;
    logic                accept;
    logic [4*DIGITS-1:0] out_ext;

    // The pointer update and the next load share one edge, so the load uses ptr_eff.
    always_comb begin
        load    = en && (!inputValid || out_ack);
        accept  = inputValid && out_ack && en;
        ptr_eff = ptr;
        if (accept) ptr_eff = (out == '0) ? PTR_MAX : out - IDX_W'(1);
        if (MODE != MODE_RR) ptr_eff = PTR_MAX;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out        <= '0;
            inputValid <= 1'b0;
            multi      <= 1'b0;
            ptr        <= PTR_MAX;
        end else if (!en) begin
            out        <= '0;
            inputValid <= 1'b0;
            multi      <= 1'b0;
        end else begin
            if (accept) ptr <= ptr_eff;
            if (load) begin
                out        <= pick(data, ptr_eff);
                inputValid <= |data;
                multi      <= |(data & (data - N'(1)));
            end
        end
    end

    always_comb begin
        out_ext            = '0;
        out_ext[IDX_W-1:0] = out;
    end

    for (genvar k = 0; k < DIGITS; k++) begin : g_digit
        hex_to_seg7 u_hex (
            .hex   (out_ext[4*k +: 4]),
            .blank (!inputValid),
            .seg   (seg[7*k +: 7])
        );
    end

endmodule

// File: tb/tb_prio_encoder_rr.sv
// Directed bench for prio_encoder_rr: fixed mode at N=16 and N=32, round-robin at N=16.
module tb_prio_encoder_rr;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] data = '0;
    logic        en = 1'b0;
    logic        out_ack = 1'b0;

    logic [3:0]  o0, o1;
    logic [4:0]  o2;
    logic        v0, v1, v2, m0, m1, m2;
    logic [6:0]  s0, s1;
    logic [13:0] s2;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    prio_encoder_rr #(.N(16), .MODE(0)) dut0 (
        .clk(clk), .rst(rst), .data(data[15:0]), .en(en), .out_ack(out_ack),
        .out(o0), .inputValid(v0), .multi(m0), .seg(s0)
    );
    prio_encoder_rr #(.N(16), .MODE(1)) dut1 (
        .clk(clk), .rst(rst), .data(data[15:0]), .en(en), .out_ack(out_ack),
        .out(o1), .inputValid(v1), .multi(m1), .seg(s1)
    );
    prio_encoder_rr #(.N(32), .MODE(0)) dut2 (
        .clk(clk), .rst(rst), .data(data), .en(en), .out_ack(out_ack),
        .out(o2), .inputValid(v2), .multi(m2), .seg(s2)
    );

    typedef struct {
        logic [31:0] d;
        logic        e;
        logic [3:0]  o16;
        logic        v16;
        logic        m16;
        logic [6:0]  s16;
        logic [4:0]  o32;
        logic        v32;
        logic        m32;
        logic [13:0] s32;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl.push_back('{32'h0000_0a40, 1'b1, 4'd11, 1'b1, 1'b1, 7'h60, 5'd11, 1'b1, 1'b1, {7'h01, 7'h60}});
        tbl.push_back('{32'h0000_0010, 1'b1, 4'd4,  1'b1, 1'b0, 7'h4C, 5'd4,  1'b1, 1'b0, {7'h01, 7'h4C}});
        tbl.push_back('{32'h0800_8000, 1'b1, 4'd15, 1'b1, 1'b0, 7'h38, 5'd27, 1'b1, 1'b1, {7'h4F, 7'h60}});
        tbl.push_back('{32'h0000_0001, 1'b1, 4'd0,  1'b1, 1'b0, 7'h01, 5'd0,  1'b1, 1'b0, {7'h01, 7'h01}});
        tbl.push_back('{32'h0000_0000, 1'b1, 4'd0,  1'b0, 1'b0, 7'h7F, 5'd0,  1'b0, 1'b0, 14'h3FFF});
        tbl.push_back('{32'h8000_0000, 1'b1, 4'd0,  1'b0, 1'b0, 7'h7F, 5'd31, 1'b1, 1'b0, {7'h4F, 7'h38}});
        tbl.push_back('{32'h0000_ffff, 1'b1, 4'd15, 1'b1, 1'b1, 7'h38, 5'd15, 1'b1, 1'b1, {7'h01, 7'h38}});
        tbl.push_back('{32'h0001_0003, 1'b1, 4'd1,  1'b1, 1'b1, 7'h4F, 5'd16, 1'b1, 1'b1, {7'h4F, 7'h01}});
        tbl.push_back('{32'hffff_ffff, 1'b0, 4'd0,  1'b0, 1'b0, 7'h7F, 5'd0,  1'b0, 1'b0, 14'h3FFF});
        tbl.push_back('{32'h0000_00a0, 1'b1, 4'd7,  1'b1, 1'b1, 7'h0F, 5'd7,  1'b1, 1'b1, {7'h01, 7'h0F}});
        tbl.push_back('{32'h0000_0004, 1'b1, 4'd2,  1'b1, 1'b0, 7'h12, 5'd2,  1'b1, 1'b0, {7'h01, 7'h12}});
        tbl.push_back('{32'h0000_0008, 1'b1, 4'd3,  1'b1, 1'b0, 7'h06, 5'd3,  1'b1, 1'b0, {7'h01, 7'h06}});
        tbl.push_back('{32'h0000_0020, 1'b1, 4'd5,  1'b1, 1'b0, 7'h24, 5'd5,  1'b1, 1'b0, {7'h01, 7'h24}});
        tbl.push_back('{32'h0000_0040, 1'b1, 4'd6,  1'b1, 1'b0, 7'h20, 5'd6,  1'b1, 1'b0, {7'h01, 7'h20}});
        tbl.push_back('{32'h0000_0100, 1'b1, 4'd8,  1'b1, 1'b0, 7'h00, 5'd8,  1'b1, 1'b0, {7'h01, 7'h00}});
        tbl.push_back('{32'h0000_0200, 1'b1, 4'd9,  1'b1, 1'b0, 7'h04, 5'd9,  1'b1, 1'b0, {7'h01, 7'h04}});
        tbl.push_back('{32'h0000_0400, 1'b1, 4'd10, 1'b1, 1'b0, 7'h08, 5'd10, 1'b1, 1'b0, {7'h01, 7'h08}});
        tbl.push_back('{32'h0000_1000, 1'b1, 4'd12, 1'b1, 1'b0, 7'h31, 5'd12, 1'b1, 1'b0, {7'h01, 7'h31}});
        tbl.push_back('{32'h0000_6000, 1'b1, 4'd14, 1'b1, 1'b1, 7'h30, 5'd14, 1'b1, 1'b1, {7'h01, 7'h30}});
        tbl.push_back('{32'h0000_2000, 1'b1, 4'd13, 1'b1, 1'b0, 7'h42, 5'd13, 1'b1, 1'b0, {7'h01, 7'h42}});

        // Reset for two cycles
        rst = 1'b1; en = 1'b1; out_ack = 1'b1; data = 32'h0000_ffff;
        step(); step();
        chk("rst out0", 32'(o0), 0);
        chk("rst valid0", 32'(v0), 0);
        chk("rst multi0", 32'(m0), 0);
        chk("rst seg0", 32'(s0), 32'h7F);
        chk("rst seg2", 32'(s2), 32'h3FFF);
        chk("rst ptr1", 32'(dut1.ptr), 15);
        rst = 1'b0;

        // Table: ack held high so every row loads
        for (int i = 0; i < tbl.size(); i++) begin
            data = tbl[i].d; en = tbl[i].e; out_ack = 1'b1;
            step();
            chk($sformatf("row%0d out16", i),   32'(o0), 32'(tbl[i].o16));
            chk($sformatf("row%0d valid16", i), 32'(v0), 32'(tbl[i].v16));
            chk($sformatf("row%0d multi16", i), 32'(m0), 32'(tbl[i].m16));
            chk($sformatf("row%0d seg16", i),   32'(s0), 32'(tbl[i].s16));
            chk($sformatf("row%0d out32", i),   32'(o2), 32'(tbl[i].o32));
            chk($sformatf("row%0d valid32", i), 32'(v2), 32'(tbl[i].v32));
            chk($sformatf("row%0d multi32", i), 32'(m2), 32'(tbl[i].m32));
            chk($sformatf("row%0d seg32", i),   32'(s2), 32'(tbl[i].s32));
        end

        // Hold: grant freezes while ack is low
        rst = 1'b1; step(); rst = 1'b0;
        data = 32'h0000_0010; en = 1'b1; out_ack = 1'b0;
        step();
        chk("hold load out", 32'(o0), 4);
        data = 32'h0000_8000;
        for (int c = 0; c < 3; c++) begin
            step();
            chk($sformatf("hold%0d out", c), 32'(o0), 4);
            chk($sformatf("hold%0d valid", c), 32'(v0), 1);
        end
        out_ack = 1'b1;
        step();
        chk("hold release out", 32'(o0), 15);

        // Round-robin rotation
        rst = 1'b1; step(); rst = 1'b0;
        data = 32'h0000_8101; en = 1'b1; out_ack = 1'b1;
        begin
            logic [3:0] exp_rr [5];
            exp_rr = '{4'd15, 4'd8, 4'd0, 4'd15, 4'd8};
            for (int c = 0; c < 5; c++) begin
                step();
                chk($sformatf("rr%0d out", c), 32'(o1), 32'(exp_rr[c]));
                chk($sformatf("rr%0d valid", c), 32'(v1), 1);
                chk($sformatf("rr%0d multi", c), 32'(m1), 1);
                if (c == 2) chk("rr ptr after 8 accepted", 32'(dut1.ptr), 7);
            end
        end
        chk("rr ptr after 15 accepted", 32'(dut1.ptr), 14);

        // Drop en with a pending grant of 8: ptr must not move
        en = 1'b0;
        step();
        chk("drop valid", 32'(v1), 0);
        chk("drop out", 32'(o1), 0);
        chk("drop ptr", 32'(dut1.ptr), 14);
        en = 1'b1;
        step();
        chk("reenable out", 32'(o1), 8);
        chk("reenable valid", 32'(v1), 1);

        // Empty request
        data = 32'h0; en = 1'b1; out_ack = 1'b1;
        step();
        chk("empty valid", 32'(v0), 0);
        chk("empty seg", 32'(s0), 32'h7F);

        // Reset in the middle of a hold, then a fresh grant without any ack
        data = 32'h0000_0010; out_ack = 1'b0;
        step(); step();
        chk("prehold valid", 32'(v1), 1);
        rst = 1'b1;
        step();
        chk("midrst out0", 32'(o0), 0);
        chk("midrst valid0", 32'(v0), 0);
        chk("midrst valid1", 32'(v1), 0);
        chk("midrst multi0", 32'(m0), 0);
        chk("midrst seg0", 32'(s0), 32'h7F);
        chk("midrst ptr1", 32'(dut1.ptr), 15);
        rst = 1'b0; data = 32'h0000_0020; out_ack = 1'b0;
        step();
        chk("postrst out0", 32'(o0), 5);
        chk("postrst out1", 32'(o1), 5);
        chk("postrst valid1", 32'(v1), 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
